serial_word_deserializer: RTL and testbench
===========================================

Name: serial_word_deserializer

Overview:
- Collects a serial bit stream into DATA_WIDTH-bit parallel words and presents each word on a valid/ready output.
- Sits directly upstream of the combinational bit-order reverser, which consumes dout. MSB_FIRST selects the assembly order, so the reverser stage can be bypassed for LSB-first links.
- One-word output register plus the assembling shift register give two words of buffering.
- Full backpressure to the serial source via din_ready.

Parameters:
- DATA_WIDTH, 32, word width in bits; legal range is at least 2.
- MSB_FIRST, 1:
  - 1 = first received bit lands in dout[DATA_WIDTH-1].
  - 0 = first received bit lands in dout[0].

Ports:
- clk  input  1  rising-edge clock
- resetn  input  1  asynchronous active-low reset
- din  input  1  serial data bit
- din_valid  input  1  din carries a bit this cycle
- din_ready  output  1  block accepts a bit this cycle (combinational from state only)
- dout  output  DATA_WIDTH  assembled word
- dout_valid  output  1  dout holds an unconsumed word
- dout_ready  input  1  downstream consumes dout this cycle
- perr  output  1  parity error flag for the word on dout; tied 0 when the optional feature is compiled out

Behaviour:
- Reset is asynchronous, active-low, and may occur mid-word:
  - Clears bit counter cnt to 0 and shift register sr to 0.
  - Drives dout=0, dout_valid=0, perr=0.
  - Any partial word is discarded, with no output for it.
- Frame length F = DATA_WIDTH, or DATA_WIDTH+1 with parity enabled. cnt ranges 0..F.
- Bit accept happens on a rising edge with din_valid && din_ready.
  - MSB_FIRST=1: sr <= {sr[DATA_WIDTH-2:0], din}.
  - MSB_FIRST=0: sr <= {din, sr[DATA_WIDTH-1:1]}.
  - cnt increments on each accept.
- slot_free = !dout_valid || dout_ready.
- Final bit accepted (cnt==F-1) with slot_free:
  - Assembled word (including this bit) loads dout directly on that edge.
  - dout_valid <= 1, cnt <= 0.
  - Latency is 0 cycles after the accept edge: dout_valid is high from that edge.
- Final bit accepted without slot_free: the word stays in sr and cnt <= F (full).
- cnt==F:
  - din_ready=0.
  - On the first edge with slot_free: dout <= sr, dout_valid <= 1, cnt <= 0.
  - din_ready returns high the cycle after the transfer.
- din_ready = (cnt != F). It never depends combinationally on din_valid or dout_ready.
- Consume: dout_valid && dout_ready on an edge with no new load sets dout_valid <= 0. dout holds its value after consumption.
- A simultaneous consume and load is legal: dout is replaced and dout_valid stays 1, giving back-to-back words at full bit rate.
- dout and perr are stable while dout_valid && !dout_ready.
- din_valid=0 gaps are permitted anywhere in a frame; sr and cnt hold.

Optional Feature:
- Macro: SERIAL_WORD_DESERIALIZER_PARITY_EN.
- Defined:
  - F = DATA_WIDTH+1; the final bit of each frame is an even-parity bit and is not shifted into sr.
  - A parity register latches the bit; with the block full, it holds the parity bit until transfer.
  - perr is loaded together with dout and equals XOR(word bits, parity bit).
  - perr=1 means odd total count of ones.
  - The word is still delivered.
- Undefined:
  - F = DATA_WIDTH, no parity register, perr constant 0.

Decomposition:
- Package serial_word_deserializer_pkg:
  - Function for frame length given width and parity enable.
  - Counter width constant: $clog2(DATA_WIDTH+2).
- Single module, no sub-module. Word assembly is one shift expression, and the output slot is one register plus valid.

Test Plan (DATA_WIDTH=4 unless noted):
- MSB_FIRST=1, dout_ready=1, bits 1,1,0,1 on consecutive cycles -> dout=4'hd with dout_valid for 1 cycle, din_ready stays 1.
- MSB_FIRST=0, same bits 1,1,0,1 -> dout=4'hb, matching the reversed view of the first case.
- Backpressure, dout_ready=0, words 1,0,0,0 then 0,0,1,1:
  - First word: dout=4'h8 held.
  - After the second word's 4th bit, din_ready=0 and dout stays 4'h8.
  - Raise dout_ready for 1 cycle -> dout=4'h3 next edge, din_ready=1 the following cycle.
  - No bits are lost.
- Reset mid-word: 2 bits accepted, pulse resetn low asynchronously between edges:
  - dout_valid=0, dout=0, din_ready=1 immediately.
  - Then bits 0,1,1,0 -> dout=4'h6.
- Gaps and back-to-back, dout_ready=1:
  - Words 4'ha and 4'h5 with din_valid gaps inside the first word -> two consecutive valid words, 4'ha then 4'h5.
  - dout_valid remains 1 across the boundary when the second word's last bit arrives on the consume edge.
- With parity macro defined:
  - 1,1,0,1 + parity 1 -> dout=4'hd, perr=0.
  - 1,1,0,1 + parity 0 -> dout=4'hd, perr=1.

Source files
------------

// File: rtl/serial_word_deserializer_pkg.sv
// -----------------------------------------------------------------------------
// serial_word_deserializer_pkg
// Shared constants and helpers for serial_word_deserializer.
//   PARITY_EN  : 1 when SERIAL_WORD_DESERIALIZER_PARITY_EN is defined, else 0
//   frame_len  : bits per serial frame (word bits, plus one parity bit if enabled)
//   cnt_width  : bit-counter width able to hold 0..frame length (DATA_WIDTH+1 max)
// Optional feature macro: SERIAL_WORD_DESERIALIZER_PARITY_EN
// -----------------------------------------------------------------------------
package serial_word_deserializer_pkg;

`ifdef SERIAL_WORD_DESERIALIZER_PARITY_EN
   localparam bit PARITY_EN = 1'b1;
`else
   localparam bit PARITY_EN = 1'b0;
`endif

   function automatic int frame_len(input int width, input bit parity_en);
      return parity_en ? width + 1 : width;
   endfunction

   function automatic int cnt_width(input int width);
      return $clog2(width + 2);
   endfunction

endpackage

// File: rtl/serial_word_deserializer.sv
// -----------------------------------------------------------------------------
// serial_word_deserializer
// Assembles a serial bit stream into DATA_WIDTH-bit words and presents them on
// a valid/ready output. The shift register plus the output register give two
// words of buffering; the serial side is backpressured through din_ready.
//
// Parameters:
//   DATA_WIDTH : word width (>= 2)
//   MSB_FIRST  : 1 = first received bit lands in dout[DATA_WIDTH-1],
//                0 = first received bit lands in dout[0]
// Ports:
//   clk        : rising-edge clock
//   resetn     : asynchronous active-low reset
//   din        : serial data bit
//   din_valid  : din carries a bit this cycle
//   din_ready  : block accepts a bit this cycle (from state only)
//   dout       : assembled word
//   dout_valid : dout holds an unconsumed word
//   dout_ready : downstream consumes dout this cycle
//   perr       : parity error for the word on dout (0 without parity)
// Optional feature macro: SERIAL_WORD_DESERIALIZER_PARITY_EN
//   Adds a trailing even-parity bit to each frame and drives perr.
// -----------------------------------------------------------------------------
module serial_word_deserializer
   import serial_word_deserializer_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter bit MSB_FIRST  = 1'b1
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  din,
   input  logic                  din_valid,
   output logic                  din_ready,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_valid,
   input  logic                  dout_ready,
   output logic                  perr
);

   localparam int FRAME = frame_len(DATA_WIDTH, PARITY_EN);
   localparam int CNT_W = cnt_width(DATA_WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME);

   logic [CNT_W-1:0]      cnt;
   logic [DATA_WIDTH-1:0] sr;
   logic [DATA_WIDTH-1:0] sr_next;
   logic [DATA_WIDTH-1:0] last_word;
   logic                  slot_free;
   logic                  accept;
   logic                  at_last;
   logic                  load_last;
   logic                  load_full;
   logic                  stash_last;

   // Every output of this block is assigned unconditionally, so no latch can form.
   always_comb begin
      sr_next   = MSB_FIRST ? {sr[DATA_WIDTH-2:0], din} : {din, sr[DATA_WIDTH-1:1]};
      // With parity the final frame bit is the parity bit, so the word is already in sr.
      last_word = PARITY_EN ? sr : sr_next;
   end

   // cnt == FRAME means a complete word is parked in sr waiting for the output slot.
   assign din_ready  = (cnt != CNT_FULL);
   assign slot_free  = !dout_valid || dout_ready;
   assign accept     = din_valid && din_ready;
   assign at_last    = accept && (cnt == CNT_LAST);
   assign load_last  = at_last && slot_free;
   assign stash_last = at_last && !slot_free;
   assign load_full  = !din_ready && slot_free;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt        <= '0;
         sr         <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
      end else begin
         // A load on the consume edge keeps dout_valid high for back-to-back words.
         if (load_last || load_full) begin
            dout       <= load_full ? sr : last_word;
            dout_valid <= 1'b1;
         end else if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
         end

         if (load_last || load_full) begin
            cnt <= '0;
         end else if (stash_last) begin
            cnt <= CNT_FULL;
         end else if (accept) begin
            cnt <= cnt + 1'b1;
         end

         // The parity bit never enters the shift register.
         if (accept && !(PARITY_EN && (cnt == CNT_LAST))) begin
            sr <= sr_next;
         end
      end
   end

`ifdef SERIAL_WORD_DESERIALIZER_PARITY_EN
   logic par;

   // perr is loaded alongside dout: XOR over the word and its parity bit, 1 = odd ones.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         par  <= 1'b0;
         perr <= 1'b0;
      end else begin
         if (stash_last) begin
            par <= din;
         end
         if (load_last) begin
            perr <= (^sr) ^ din;
         end else if (load_full) begin
            perr <= (^sr) ^ par;
         end
      end
   end
`else
   assign perr = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_deserializer.sv
// -----------------------------------------------------------------------------
// tb_serial_word_deserializer
// Drives two DATA_WIDTH=4 instances (MSB_FIRST=1 and MSB_FIRST=0) with the same
// serial stream. Expected words are queued when a frame is issued; a monitor
// pops and compares whenever a word is consumed (dout_valid && dout_ready).
// Directed checks cover reset, backpressure, mid-word reset and the
// back-to-back boundary.
// -----------------------------------------------------------------------------
module tb_serial_word_deserializer;

`ifdef SERIAL_WORD_DESERIALIZER_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   typedef struct packed {
      logic [3:0] data;
      logic       perr;
   } exp_t;

   logic       clk;
   logic       resetn;
   logic       din;
   logic       din_valid;
   logic       dout_ready;
   logic       rdy_m, rdy_l;
   logic [3:0] dout_m, dout_l;
   logic       dv_m, dv_l;
   logic       perr_m, perr_l;

   int checks   = 0;
   int failures = 0;

   exp_t q_m[$];
   exp_t q_l[$];

   serial_word_deserializer #(.DATA_WIDTH(4), .MSB_FIRST(1'b1)) dut_msb (
      .clk        (clk),
      .resetn     (resetn),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (rdy_m),
      .dout       (dout_m),
      .dout_valid (dv_m),
      .dout_ready (dout_ready),
      .perr       (perr_m)
   );

   serial_word_deserializer #(.DATA_WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
      .clk        (clk),
      .resetn     (resetn),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (rdy_l),
      .dout       (dout_l),
      .dout_valid (dv_l),
      .dout_ready (dout_ready),
      .perr       (perr_l)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // perr_if_parity is the expected flag in a parity build; without parity perr is 0.
   task automatic push(input logic [3:0] m, input logic [3:0] l, input logic perr_if_parity);
      exp_t e;
      e.perr = PAR ? perr_if_parity : 1'b0;
      e.data = m;
      q_m.push_back(e);
      e.data = l;
      q_l.push_back(e);
   endtask

   // Present one bit from a falling edge; it is taken at the next rising edge with din_ready.
   task automatic put_bit(input logic b, input bit rdy_on);
      int n;
      @(negedge clk);
      din       = b;
      din_valid = 1'b1;
      if (rdy_on) dout_ready = 1'b1;
      n = 0;
      while (!rdy_m && n < 64) begin
         @(negedge clk);
         n++;
      end
      if (n >= 64) begin
         checks++;
         failures++;
         $display("FAIL din_ready_timeout: got 0 expected 1 within 64 cycles");
      end
   endtask

   // Bits go out v[3] first; the parity bit is appended only in a parity build.
   task automatic send_frame(input logic [3:0] v, input logic p, input bit rdy_last);
      for (int i = 3; i >= 0; i--) begin
         put_bit(v[i], rdy_last && !PAR && (i == 0));
      end
      if (PAR) put_bit(p, rdy_last);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         din_valid = 1'b0;
      end
   endtask

   // Scoreboard monitor: every consumed word must match the head of its queue.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (resetn && dv_m && dout_ready) begin
            if (q_m.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL msb_unexpected_word: got %0h expected none", dout_m);
            end else begin
               e = q_m.pop_front();
               check("msb_word", dout_m, e.data);
               check("msb_perr", perr_m, e.perr);
            end
         end
         if (resetn && dv_l && dout_ready) begin
            if (q_l.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL lsb_unexpected_word: got %0h expected none", dout_l);
            end else begin
               e = q_l.pop_front();
               check("lsb_word", dout_l, e.data);
               check("lsb_perr", perr_l, e.perr);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      resetn     = 1'b0;
      din        = 1'b0;
      din_valid  = 1'b0;
      dout_ready = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      check("rst_dout", dout_m, 4'h0);
      check("rst_valid", dv_m, 1'b0);
      check("rst_din_ready", rdy_m, 1'b1);
      check("rst_perr", perr_m, 1'b0);
      resetn = 1'b1;
      @(negedge clk);
      dout_ready = 1'b1;

      // Basic word, both bit orders: 1,1,0,1 -> msb d, lsb b
      push(4'hd, 4'hb, 1'b0);
      send_frame(4'b1101, 1'b1, 1'b0);
      @(negedge clk);
      din_valid = 1'b0;
      #1;
      check("basic_valid", dv_m, 1'b1);
      check("basic_din_ready", rdy_m, 1'b1);
      @(negedge clk);
      #1;
      check("basic_valid_drop", dv_m, 1'b0);

      // Same word with a wrong parity bit (perr only in a parity build)
      push(4'hd, 4'hb, 1'b1);
      send_frame(4'b1101, 1'b0, 1'b0);
      idle(2);

      // Backpressure: two words, second parks in the shift register
      @(negedge clk);
      dout_ready = 1'b0;
      push(4'h8, 4'h1, 1'b0);
      push(4'h3, 4'hc, 1'b0);
      send_frame(4'b1000, 1'b1, 1'b0);
      send_frame(4'b0011, 1'b0, 1'b0);
      @(negedge clk);
      din_valid = 1'b0;
      #1;
      check("bp_din_ready_full", rdy_m, 1'b0);
      check("bp_dout_held", dout_m, 4'h8);
      check("bp_valid_held", dv_m, 1'b1);
      repeat (3) @(negedge clk);
      #1;
      check("bp_dout_still", dout_m, 4'h8);
      check("bp_din_ready_still", rdy_m, 1'b0);
      @(negedge clk);
      dout_ready = 1'b1;
      @(negedge clk);
      dout_ready = 1'b0;
      #1;
      check("bp_dout_second", dout_m, 4'h3);
      check("bp_dout_second_lsb", dout_l, 4'hc);
      check("bp_valid_second", dv_m, 1'b1);
      check("bp_din_ready_back", rdy_m, 1'b1);
      @(negedge clk);
      dout_ready = 1'b1;
      idle(2);

      // Reset mid-word: two bits taken, then an asynchronous pulse between edges
      put_bit(1'b1, 1'b0);
      put_bit(1'b0, 1'b0);
      @(negedge clk);
      din_valid = 1'b0;
      #2;
      resetn = 1'b0;
      #1;
      check("mid_rst_valid", dv_m, 1'b0);
      check("mid_rst_dout", dout_m, 4'h0);
      check("mid_rst_din_ready", rdy_m, 1'b1);
      check("mid_rst_perr", perr_m, 1'b0);
      resetn = 1'b1;
      push(4'h6, 4'h6, 1'b0);
      send_frame(4'b0110, 1'b0, 1'b0);
      idle(2);

      // Gaps inside the first word, second word completes on the consume edge
      @(negedge clk);
      dout_ready = 1'b0;
      push(4'ha, 4'h5, 1'b0);
      push(4'h5, 4'ha, 1'b0);
      put_bit(1'b1, 1'b0);
      idle(2);
      put_bit(1'b0, 1'b0);
      idle(1);
      put_bit(1'b1, 1'b0);
      put_bit(1'b0, 1'b0);
      if (PAR) put_bit(1'b0, 1'b0);
      send_frame(4'b0101, 1'b0, 1'b1);
      @(negedge clk);
      din_valid = 1'b0;
      #1;
      check("b2b_valid_kept", dv_m, 1'b1);
      check("b2b_dout", dout_m, 4'h5);
      @(negedge clk);
      #1;
      check("b2b_valid_drop", dv_m, 1'b0);

      idle(4);
      check("sb_empty_msb", q_m.size(), 0);
      check("sb_empty_lsb", q_l.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
